// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit for RV64M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// A radix-2 shift-add multiplier and a restoring divider share one 2N-bit
// working register. Latency is fixed at N+1 edges after accept. Divide-by-zero
// and signed overflow take a one-edge early-out path.
module ula_muldiv #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    input  logic         start,
    input  logic         flush,
    output logic         ready,
    output logic         valid,
    output logic [N-1:0] Y
);
    localparam int CW = $clog2(N);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [N-1:0]   r_abs_a;
    logic [N-1:0]   r_abs_b;
    logic [2:0]     r_op;
    logic           r_sign_a;
    logic           r_sign_b;
    logic           r_special;  // result already preset in r_acc low half
    logic           r_valid;
    logic [N-1:0]   r_y;

    // Operand decode at the accept edge: signedness, magnitudes, early-out cases
    logic           w_a_signed;
    logic           w_b_signed;
    logic           w_sign_a;
    logic           w_sign_b;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic           w_b_zero;
    logic           w_overflow;
    logic           w_special;
    logic [N-1:0]   w_preset;

    always_comb begin
        w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_sign_a   = w_a_signed & A[N-1];
        w_sign_b   = w_b_signed & B[N-1];
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        w_abs_a    = w_sign_a ? (~A + ONE_N) : A;
        w_abs_b    = w_sign_b ? (~B + ONE_N) : B;
        w_b_zero   = (B == '0);
        w_overflow = (A == MOST_NEG) && (B == '1) && (op == OP_DIV || op == OP_REM);
        w_special  = 1'b0;
        w_preset   = '0;
        if (op[2] && w_b_zero) begin
            w_special = 1'b1;
            w_preset  = op[1] ? A : '1;
        end else if (w_overflow) begin
            w_special = 1'b1;
            w_preset  = op[1] ? '0 : A;
        end
    end

    // One iteration step for each algorithm, and the sign-corrected final result
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_rem_shift;
    logic [N:0]     w_trial;
    logic           w_fits;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_result;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_abs_a} : {(N+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[N-1:1]};
        w_rem_shift = {r_acc[2*N-1:N], r_acc[N-1]};
        w_trial     = w_rem_shift - {1'b0, r_abs_b};
        w_fits      = ~w_trial[N];
        w_div_next  = {(w_fits ? w_trial[N-1:0] : w_rem_shift[N-1:0]), r_acc[N-2:0], w_fits};

        w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + ONE_2N) : r_acc;
        w_quot = (r_sign_a ^ r_sign_b) ? (~r_acc[N-1:0] + ONE_N) : r_acc[N-1:0];
        w_rem  = r_sign_a ? (~r_acc[2*N-1:N] + ONE_N) : r_acc[2*N-1:N];

        if (r_special) begin
            w_result = r_acc[N-1:0];
        end else begin
            case (r_op)
                3'b000:                 w_result = w_prod[N-1:0];
                3'b001, 3'b010, 3'b011: w_result = w_prod[2*N-1:N];
                3'b100, 3'b101:         w_result = w_quot;
                default:                w_result = w_rem;
            endcase
        end
    end

    // Control FSM with working register, counter and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_abs_a   <= '0;
            r_abs_b   <= '0;
            r_op      <= OP_MUL;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_special <= 1'b0;
            r_valid   <= 1'b0;
            r_y       <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op      <= op;
                        r_sign_a  <= w_sign_a;
                        r_sign_b  <= w_sign_b;
                        r_abs_a   <= w_abs_a;
                        r_abs_b   <= w_abs_b;
                        r_special <= w_special;
                        if (w_special) begin
                            r_acc   <= {{N{1'b0}}, w_preset};
                            r_state <= S_FINISH;
                        end else begin
                            r_acc   <= {{N{1'b0}}, (op[2] ? w_abs_a : w_abs_b)};
                            r_cnt   <= CW'(N - 1);
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        if (r_cnt == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    if (!flush) begin
                        r_y     <= w_result;
                        r_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready = (r_state == S_IDLE);
    assign valid = r_valid;
    assign Y     = r_y;
endmodule

// File: tb/tb_ula_muldiv.sv
// Self-checking bench for ula_muldiv: directed N=8 cases, back-to-back random
// N=8 operations and N=64 corner/random operations against an arithmetic model.
module tb_ula_muldiv;
    logic        clock = 1'b0;
    logic        reset_n;

    logic [7:0]  a8, b8, y8;
    logic [2:0]  op8;
    logic        start8, flush8, ready8, valid8;

    logic [63:0] a64, b64, y64;
    logic [2:0]  op64;
    logic        start64, flush64, ready64, valid64;

    int n_cmp = 0;
    int n_bad = 0;

    ula_muldiv #(.N(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .A(a8), .B(b8), .op(op8),
        .start(start8), .flush(flush8), .ready(ready8), .valid(valid8), .Y(y8)
    );

    ula_muldiv #(.N(64)) u_dut64 (
        .clock(clock), .reset_n(reset_n), .A(a64), .B(b64), .op(op64),
        .start(start64), .flush(flush64), .ready(ready64), .valid(valid64), .Y(y64)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension result from plain wide integer arithmetic
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic signed [129:0] full, half, mask, au, bu, as_v, bs_v, r;
        full = 130'sd1 <<< w;
        half = full >>> 1;
        mask = full - 130'sd1;
        au   = $signed({66'd0, a}) & mask;
        bu   = $signed({66'd0, b}) & mask;
        as_v = (au >= half) ? au - full : au;
        bs_v = (bu >= half) ? bu - full : bu;
        case (o)
            3'd0: r = au * bu;
            3'd1: r = (as_v * bs_v) >>> w;
            3'd2: r = (as_v * bu) >>> w;
            3'd3: r = (au * bu) >>> w;
            3'd4: begin
                if (bu == 0)                                r = mask;
                else if (as_v == -half && bs_v == -130'sd1) r = au;
                else                                        r = as_v / bs_v;
            end
            3'd5: r = (bu == 0) ? mask : au / bu;
            3'd6: begin
                if (bu == 0)                                r = au;
                else if (as_v == -half && bs_v == -130'sd1) r = 130'sd0;
                else                                        r = as_v % bs_v;
            end
            default: r = (bu == 0) ? au : au % bu;
        endcase
        r = r & mask;
        return r[63:0];
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [63:0] a,
                                      input logic [63:0] b, input int w);
        logic [63:0] mask, msb;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        msb  = 64'd1 << (w - 1);
        return (o[2] && ((b & mask) == 64'd0)) ||
               ((o == 3'd4 || o == 3'd6) && a == msb && b == mask);
    endfunction

    // One operation: accept, confirm busy, then check latency and result
    task automatic run_op(input bit wide, input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input string tag);
        int w, lat, seen;
        logic [63:0] y;
        w   = wide ? 64 : 8;
        lat = is_special(o, a, b, w) ? 1 : w + 1;
        if (wide) begin
            op64 = o; a64 = a; b64 = b; start64 = 1'b1;
        end else begin
            op8 = o; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end
        @(posedge clock); #1;
        start8  = 1'b0;
        start64 = 1'b0;
        check_value({tag, "/busy"}, {63'd0, (wide ? ready64 : ready8)}, 64'd0);
        check_value({tag, "/nopulse"}, {63'd0, (wide ? valid64 : valid8)}, 64'd0);
        seen = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clock); #1;
            if (wide ? valid64 : valid8) begin
                seen = k;
                break;
            end
        end
        check_value({tag, "/lat"}, 64'(seen), 64'(lat));
        y = wide ? y64 : {56'd0, y8};
        check_value({tag, "/Y"}, y, exp);
        $display("op=%0d A=0x%0h B=0x%0h Y=0x%0h lat=%0d (%s)", o, a, b, y, seen, tag);
    endtask

    task automatic watch_quiet(input int cycles, input string tag);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(posedge clock); #1;
            if (valid8) hits++;
        end
        check_value(tag, 64'(hits), 64'd0);
    endtask

    logic [63:0] corners [4];
    logic [2:0]  ro;
    logic [63:0] ra, rb;
    int          seen_i;

    initial begin
        reset_n = 1'b0;
        a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0; flush8 = 1'b0;
        a64 = '0; b64 = '0; op64 = '0; start64 = 1'b0; flush64 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_value("reset/ready", {63'd0, ready8}, 64'd1);
        check_value("reset/valid", {63'd0, valid8}, 64'd0);
        check_value("reset/Y", {56'd0, y8}, 64'd0);
        check_value("reset/ready64", {63'd0, ready64}, 64'd1);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed multiply and divide
        run_op(0, 3'd0, 64'd13,   64'd11,   64'h8F, "MUL");
        run_op(0, 3'd1, 64'hF3,   64'd11,   64'hFF, "MULH");
        run_op(0, 3'd3, 64'hFF,   64'hFF,   64'hFE, "MULHU");
        run_op(0, 3'd2, 64'hFF,   64'hFF,   64'hFF, "MULHSU");
        run_op(0, 3'd4, 64'hF9,   64'd2,    64'hFD, "DIV");
        run_op(0, 3'd6, 64'hF9,   64'd2,    64'hFF, "REM");
        run_op(0, 3'd5, 64'd200,  64'd7,    64'd28, "DIVU");
        run_op(0, 3'd7, 64'd200,  64'd7,    64'd4,  "REMU");
        // Early-out cases
        run_op(0, 3'd5, 64'h25,   64'd0,    64'hFF, "DIVU0");
        run_op(0, 3'd7, 64'h25,   64'd0,    64'h25, "REMU0");
        run_op(0, 3'd4, 64'h80,   64'hFF,   64'h80, "DIVOVF");
        run_op(0, 3'd6, 64'h80,   64'hFF,   64'h00, "REMOVF");

        // start during RUN is ignored, and input changes after accept have no effect
        op8 = 3'd0; a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
        @(posedge clock); #1;
        op8 = 3'd5; a8 = 8'd200; b8 = 8'd7;
        repeat (3) @(posedge clock);
        #1;
        start8 = 1'b0;
        seen_i = 0;
        for (int k = 4; k <= 40; k++) begin
            @(posedge clock); #1;
            if (valid8) begin
                seen_i = k;
                break;
            end
        end
        check_value("ignore/lat", 64'(seen_i), 64'd9);
        check_value("ignore/Y", {56'd0, y8}, 64'h8F);
        $display("ignore: Y=0x%0h lat=%0d", y8, seen_i);
        watch_quiet(12, "ignore/noqueue");

        // flush on edge e4 aborts without a pulse and Y keeps the prior result
        op8 = 3'd0; a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        flush8 = 1'b1;
        @(posedge clock); #1;
        flush8 = 1'b0;
        check_value("flush/ready", {63'd0, ready8}, 64'd1);
        check_value("flush/valid", {63'd0, valid8}, 64'd0);
        check_value("flush/Yhold", {56'd0, y8}, 64'h8F);
        $display("flush: ready=%0d Y=0x%0h", ready8, y8);
        watch_quiet(12, "flush/quiet");
        run_op(0, 3'd0, 64'd3, 64'd5, 64'd15, "MUL3x5");

        // flush and start together in IDLE: not accepted
        op8 = 3'd0; a8 = 8'd2; b8 = 8'd2; flush8 = 1'b1; start8 = 1'b1;
        @(posedge clock); #1;
        flush8 = 1'b0; start8 = 1'b0;
        check_value("flushstart/ready", {63'd0, ready8}, 64'd1);
        watch_quiet(12, "flushstart/quiet");
        check_value("flushstart/Y", {56'd0, y8}, 64'd15);
        $display("flush+start: ready=%0d Y=0x%0h", ready8, y8);

        // Asynchronous reset mid-RUN
        op8 = 3'd0; a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_value("arst/ready", {63'd0, ready8}, 64'd1);
        check_value("arst/valid", {63'd0, valid8}, 64'd0);
        check_value("arst/Y", {56'd0, y8}, 64'd0);
        $display("async reset: ready=%0d valid=%0d Y=0x%0h", ready8, valid8, y8);
        @(negedge clock) reset_n = 1'b1;
        watch_quiet(12, "arst/quiet");

        // Back-to-back random N=8 operations
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rb = 64'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 64'h80;
                rb = 64'hFF;
            end
            run_op(0, ro, ra, rb, ref_op(ro, ra, rb, 8), "rand8");
        end

        // N=64 corner operands for every op, then random
        corners[0] = 64'd0;
        corners[1] = 64'd1;
        corners[2] = 64'h8000_0000_0000_0000;
        corners[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    run_op(1, 3'(o), corners[i], corners[j],
                           ref_op(3'(o), corners[i], corners[j], 64), "corner64");
                end
            end
        end
        for (int i = 0; i < 80; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 62);
            run_op(1, ro, ra, rb, ref_op(ro, ra, rb, 64), "rand64");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
